ped_button_conditioner: RTL and testbench

Conditions the raw pedestrian push-button before it reaches the light-sequencing FSM. It synchronises the raw input, debounces it, and produces a one-cycle press pulse. It holds a pending crossing request until the FSM acknowledges it, then applies a post-service lockout so that repeated presses cannot re-trigger a crossing immediately. It sits between the board button pin and the FSM's button input, in the same clock domain as the FSM and timer.

---
 rtl/ped_button_conditioner.sv | 141 ++++++++++++++
 tb/tb_ped_button_conditioner.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ped_button_conditioner.sv
// Pedestrian push-button conditioner: 2-flop synchroniser, debouncer, press pulse,
// request hold until acknowledge, and post-service lockout with a dropped-press counter.
`timescale 1ns/1ps
module ped_button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned LOCKOUT_CYCLES  = 200000000,
    parameter int unsigned CNT_W           = 28
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       button_raw,
    input  logic       ack,
    output logic       btn_level,
    output logic       btn_pulse,
    output logic       req,
    output logic       lockout,
    output logic [7:0] drop_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_LOCKOUT = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCKOUT_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(32'd1);

    logic [1:0]       sync_q;
    logic             level_q,   level_d;
    logic             pulse_q,   pulse_d;
    logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
    state_e           state_q,   state_d;
    logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic [7:0]       drop_q,    drop_d;
    logic             req_q,     req_d;
    logic             lockout_q, lockout_d;

    // Debounce: the stable level flips only after the synchronised input has
    // disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
    always_comb begin
        level_d   = level_q;
        deb_cnt_d = deb_cnt_q;
        pulse_d   = 1'b0;
        if (sync_q[1] != level_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                level_d   = sync_q[1];
                deb_cnt_d = CNT_ZERO;
                pulse_d   = sync_q[1];
            end else begin
                deb_cnt_d = deb_cnt_q + CNT_ONE;
            end
        end else begin
            deb_cnt_d = CNT_ZERO;
        end
    end

    // Request / lockout sequencing driven by the registered press pulse.
    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        drop_d     = drop_q;
        case (state_q)
            ST_IDLE: begin
                if (pulse_q) begin
                    state_d = ST_PENDING;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PENDING: begin
                if (ack) begin
                    state_d    = ST_LOCKOUT;
                    lock_cnt_d = CNT_ZERO;
                end else begin
                    state_d = ST_PENDING;
                end
            end
            ST_LOCKOUT: begin
                if (pulse_q && (drop_q != 8'hFF)) begin
                    drop_d = drop_q + 8'd1;
                end else begin
                    drop_d = drop_q;
                end
                if (lock_cnt_q == LOCK_LAST) begin
                    state_d    = ST_IDLE;
                    lock_cnt_d = CNT_ZERO;
                end else begin
                    lock_cnt_d = lock_cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                lock_cnt_d = CNT_ZERO;
            end
        endcase
        req_d     = (state_d == ST_PENDING);
        lockout_d = (state_d == ST_LOCKOUT);
    end

    // Synchroniser and debounce state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q    <= 2'b00;
            level_q   <= 1'b0;
            pulse_q   <= 1'b0;
            deb_cnt_q <= CNT_ZERO;
        end else begin
            sync_q    <= {sync_q[0], button_raw};
            level_q   <= level_d;
            pulse_q   <= pulse_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    // Sequencer state and registered request/lockout flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            lock_cnt_q <= CNT_ZERO;
            drop_q     <= 8'd0;
            req_q      <= 1'b0;
            lockout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            drop_q     <= drop_d;
            req_q      <= req_d;
            lockout_q  <= lockout_d;
        end
    end

    assign btn_level = level_q;
    assign btn_pulse = pulse_q;
    assign req       = req_q;
    assign lockout   = lockout_q;
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_ped_button_conditioner.sv
// Randomised and directed bench for ped_button_conditioner against a run-length /
// timestamp behavioural model, with literal checkpoints from the test plan.
`timescale 1ns/1ps
module tb_ped_button_conditioner;

    localparam int DEB  = 4;
    localparam int LOCK = 8;

    logic       clk;
    logic       reset;
    logic       button_raw;
    logic       ack;
    logic       btn_level;
    logic       btn_pulse;
    logic       req;
    logic       lockout;
    logic [7:0] drop_cnt;

    int n_checks = 0;
    int n_errors = 0;
    bit auto_ack = 1'b0;

    // Behavioural model: raw history, run length of disagreement, lockout end timestamp.
    int edge_no  = 0;
    bit m_s1     = 1'b0;
    bit m_s2     = 1'b0;
    bit m_level  = 1'b0;
    int m_run    = 0;
    bit m_pulse  = 1'b0;
    bit m_req    = 1'b0;
    bit m_lock   = 1'b0;
    int m_lock_end = 0;
    int m_drop   = 0;

    ped_button_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .LOCKOUT_CYCLES (LOCK),
        .CNT_W          (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .button_raw(button_raw),
        .ack       (ack),
        .btn_level (btn_level),
        .btn_pulse (btn_pulse),
        .req       (req),
        .lockout   (lockout),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_s1 = 1'b0; m_s2 = 1'b0; m_level = 1'b0; m_run = 0; m_pulse = 1'b0;
            m_req = 1'b0; m_lock = 1'b0; m_lock_end = 0; m_drop = 0;
        end else begin
            edge_no++;
            if (m_lock && m_pulse && m_drop < 255) m_drop++;
            if (m_req && ack) begin
                m_req = 1'b0;
                m_lock_end = edge_no + LOCK;
            end else if (!m_req && !m_lock && m_pulse) begin
                m_req = 1'b1;
            end
            m_lock = (edge_no < m_lock_end);
            m_pulse = 1'b0;
            if (m_s2 != m_level) begin
                m_run++;
                if (m_run == DEB) begin
                    m_level = m_s2;
                    m_run = 0;
                    m_pulse = m_s2;
                end
            end else begin
                m_run = 0;
            end
            m_s2 = m_s1;
            m_s1 = button_raw;
        end
    end

    always @(negedge clk) begin
        chk("btn_level", {7'd0, btn_level}, {7'd0, m_level});
        chk("btn_pulse", {7'd0, btn_pulse}, {7'd0, m_pulse});
        chk("req",       {7'd0, req},       {7'd0, m_req});
        chk("lockout",   {7'd0, lockout},   {7'd0, m_lock});
        chk("drop_cnt",  drop_cnt,          8'(m_drop));
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (auto_ack) ack = m_req && ($urandom_range(0, 2) != 0);
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic wait_req(input int bound);
        int k = 0;
        while (!m_req && k < bound) begin
            step();
            k++;
        end
        chk("wait_req", {7'd0, req}, 8'd1);
    endtask

    initial begin
        reset = 1'b0; button_raw = 1'b1; ack = 1'b0;
        steps(3);
        chk("rst_level", {7'd0, btn_level}, 8'd0);
        chk("rst_pulse", {7'd0, btn_pulse}, 8'd0);
        chk("rst_req",   {7'd0, req},       8'd0);
        chk("rst_lock",  {7'd0, lockout},   8'd0);
        chk("rst_drop",  drop_cnt,          8'd0);

        // Clean rise held through reset release.
        reset = 1'b1;
        steps(5);
        chk("lat_level_e5", {7'd0, btn_level}, 8'd0);
        step();
        chk("lat_level_e6", {7'd0, btn_level}, 8'd1);
        chk("lat_pulse_e6", {7'd0, btn_pulse}, 8'd1);
        step();
        chk("lat_req_e7",   {7'd0, req},       8'd1);
        chk("lat_pulse_e7", {7'd0, btn_pulse}, 8'd0);

        // Handshake with the button still held.
        ack = 1'b1; step(); ack = 1'b0;
        chk("hs_req",  {7'd0, req},     8'd0);
        chk("hs_lock", {7'd0, lockout}, 8'd1);
        steps(7);
        chk("hs_lock_last", {7'd0, lockout}, 8'd1);
        step();
        chk("hs_lock_end", {7'd0, lockout}, 8'd0);
        steps(4);
        chk("held_no_req", {7'd0, req}, 8'd0);
        button_raw = 1'b0; steps(8);

        // Bounce then stable rise.
        button_raw = 1'b1; step(); button_raw = 1'b0; step();
        button_raw = 1'b1; step(); button_raw = 1'b0; step();
        button_raw = 1'b1;
        steps(5);
        chk("bnc_level_e5", {7'd0, btn_level}, 8'd0);
        step();
        chk("bnc_pulse_e6", {7'd0, btn_pulse}, 8'd1);
        step();
        chk("bnc_req", {7'd0, req}, 8'd1);

        // Two presses dropped, each inside its own lockout window.
        button_raw = 1'b0; steps(6);
        ack = 1'b1; step(); ack = 1'b0;
        button_raw = 1'b1; steps(7); button_raw = 1'b0; steps(4);
        chk("drop_one", drop_cnt, 8'd1);
        button_raw = 1'b1; wait_req(30);
        button_raw = 1'b0; steps(6);
        ack = 1'b1; step(); ack = 1'b0;
        button_raw = 1'b1; steps(7); button_raw = 1'b0; steps(6);
        chk("drop_two", drop_cnt, 8'd2);
        chk("drop_no_req", {7'd0, req}, 8'd0);
        button_raw = 1'b1; wait_req(30);

        // Pulse and ack in the same cycle, then reset mid-lockout.
        button_raw = 1'b0; steps(6);
        button_raw = 1'b1;
        for (int k = 0; k < 30 && !m_pulse; k++) step();
        chk("sim_pulse_seen", {7'd0, btn_pulse}, 8'd1);
        ack = 1'b1; step(); ack = 1'b0;
        chk("sim_lock", {7'd0, lockout}, 8'd1);
        chk("sim_drop", drop_cnt, 8'd2);
        steps(3);
        button_raw = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("async_drop", drop_cnt, 8'd0);
        chk("async_lock", {7'd0, lockout}, 8'd0);
        chk("async_req",  {7'd0, req}, 8'd0);
        step();
        reset = 1'b1;

        // Random bouncy input with random acknowledge.
        auto_ack = 1'b1;
        for (int i = 0; i < 300; i++) begin
            button_raw = 1'($urandom_range(0, 1));
            steps($urandom_range(1, 8));
        end

        // Saturation of the dropped-press counter.
        for (int i = 0; i < 600; i++) begin
            button_raw = 1'b1; steps(4);
            button_raw = 1'b0; steps(4);
        end
        chk("drop_sat", drop_cnt, 8'd255);

        // Held button through the end of lockout.
        auto_ack = 1'b0; ack = 1'b0;
        steps(12);
        if (m_req) begin
            ack = 1'b1; step(); ack = 1'b0;
        end
        steps(10);
        button_raw = 1'b1; wait_req(30);
        ack = 1'b1; step(); ack = 1'b0;
        steps(20);
        chk("hold_no_req",  {7'd0, req},     8'd0);
        chk("hold_no_lock", {7'd0, lockout}, 8'd0);
        chk("hold_sat",     drop_cnt,        8'd255);
        button_raw = 1'b0; steps(6);
        button_raw = 1'b1; wait_req(30);
        steps(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
